// File: rtl/sign_restore.sv
// Magnitude + sign back to WL-bit two's complement, clamping out-of-range results.
// Two-stage elastic valid/ready pipeline with a saturating count of clamped outputs.
module sign_restore #(
  parameter int unsigned WL = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_mag,
  input  logic          in_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_data,
  output logic          out_sat,
  input  logic          sat_clear,
  output logic [CW-1:0] sat_count
);

  localparam logic [WL-1:0] MaxP   = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] MinN   = {1'b1, {(WL-1){1'b0}}};
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  logic          s1_valid_q, s1_valid_d;
  logic [WL-1:0] s1_mag_q;
  logic          s1_sign_q;
  logic          out_valid_q, out_valid_d;
  logic [WL-1:0] out_data_q, out_data_d;
  logic          out_sat_q, out_sat_d;
  logic [CW-1:0] sat_count_q, sat_count_d;

  logic          in_xfer;
  logic          out_xfer;
  logic          s2_load;
  logic [WL-1:0] res_data;
  logic          res_sat;

  // Stage 2 frees up whenever it is empty or its contents leave this cycle.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // Stage-2 arithmetic: negate on request, clamp to the representable range.
  always_comb begin
    res_data = s1_mag_q;
    res_sat  = 1'b0;
    if (!s1_sign_q) begin
      if (s1_mag_q > MaxP) begin
        res_data = MaxP;
        res_sat  = 1'b1;
      end
    end else begin
      if (s1_mag_q > MinN) begin
        res_data = MinN;
        res_sat  = 1'b1;
      end else begin
        res_data = ~s1_mag_q + {{(WL-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = res_data;
      out_sat_d   = res_sat;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_xfer && out_sat_q && (sat_count_q != CntMax)) begin
      sat_count_d = sat_count_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_sign_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_xfer) begin
        s1_mag_q  <= in_mag;
        s1_sign_q <= in_sign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sign_restore.sv
// Bench for sign_restore (WL=8, CW=2): vector table, scoreboard monitor, latency,
// stall, saturation-count and asynchronous-reset sequences.
module tb_sign_restore;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, in_sign, out_valid, out_ready, out_sat, sat_clear;
  logic [7:0] in_mag, out_data;
  logic [1:0] sat_count;

  sign_restore #(.WL(8), .CW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clear (sat_clear),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mag;
    logic       sign;
    logic [7:0] d;
    logic       s;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         delivered = 0;
  logic [8:0] q[$];  // {sat, data} of accepted, not yet delivered samples
  logic [8:0] popped;
  logic [7:0] exp_d;
  logic       exp_s;
  logic       rand_ready = 1'b0;
  logic       stalled_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_sat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: signed value then clamp to [-128, 127].
  function automatic logic [8:0] model(input logic [7:0] mag, input logic sign);
    int v;
    logic s;
    v = sign ? -int'(mag) : int'(mag);
    s = 1'b0;
    if (v > 127) begin
      v = 127;
      s = 1'b1;
    end
    if (v < -128) begin
      v = -128;
      s = 1'b1;
    end
    return {s, 8'(v)};
  endfunction

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      check("in_ready_rule", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      if (stalled_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_sat", 32'(out_sat), 32'(prev_sat));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          popped = q.pop_front();
          check("sb_data", 32'(out_data), 32'(popped[7:0]));
          check("sb_sat", 32'(out_sat), 32'(popped[8]));
          delivered++;
        end
      end
      if (in_valid && in_ready) q.push_back({exp_s, exp_d});
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
      prev_sat     = out_sat;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] m, input logic s, input logic [7:0] ed, input logic es);
    int   n;
    logic acc;
    in_mag   = m;
    in_sign  = s;
    exp_d    = ed;
    exp_s    = es;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 300 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Pipeline must be empty with out_ready=1.
  task automatic latency(input logic [7:0] m, input logic s, input logic [7:0] ed,
                         input logic es, input string tag);
    in_mag   = m;
    in_sign  = s;
    exp_d    = ed;
    exp_s    = es;
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_cycle1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_cycle2_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(ed));
    check({tag, "_sat"}, 32'(out_sat), 32'(es));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl[10];
    logic [8:0] r;
    logic [7:0] xv;
    logic [7:0] mv;
    int         n;
    int         stale;

    tbl[0] = '{mag: 8'd128, sign: 1'b1, d: 8'h80, s: 1'b0};
    tbl[1] = '{mag: 8'd128, sign: 1'b0, d: 8'h7F, s: 1'b1};
    tbl[2] = '{mag: 8'd200, sign: 1'b1, d: 8'h80, s: 1'b1};
    tbl[3] = '{mag: 8'd0,   sign: 1'b1, d: 8'h00, s: 1'b0};
    tbl[4] = '{mag: 8'd127, sign: 1'b0, d: 8'h7F, s: 1'b0};
    tbl[5] = '{mag: 8'd5,   sign: 1'b1, d: 8'hFB, s: 1'b0};
    tbl[6] = '{mag: 8'd255, sign: 1'b0, d: 8'h7F, s: 1'b1};
    tbl[7] = '{mag: 8'd129, sign: 1'b1, d: 8'h80, s: 1'b1};
    tbl[8] = '{mag: 8'd1,   sign: 1'b1, d: 8'hFF, s: 1'b0};
    tbl[9] = '{mag: 8'd0,   sign: 1'b0, d: 8'h00, s: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_mag = '0; in_sign = 1'b0;
    out_ready = 1'b0; sat_clear = 1'b0; exp_d = '0; exp_s = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    latency(8'd5, 1'b1, 8'hFB, 1'b0, "t1");

    foreach (tbl[i]) send(tbl[i].mag, tbl[i].sign, tbl[i].d, tbl[i].s);
    drain();

    delivered = 0;
    rand_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      r = model(8'(i), (i % 3) == 0);
      send(8'(i), (i % 3) == 0, r[7:0], r[8]);
    end
    drain();
    check("stream_count", 32'(delivered), 32'd21);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    delivered = 0;
    for (int x = 0; x < 256; x++) begin
      xv = 8'(x);
      mv = xv[7] ? (~xv + 8'd1) : xv;
      send(mv, xv[7], xv, 1'b0);
    end
    drain();
    check("roundtrip_count", 32'(delivered), 32'd256);

    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
    check("sat_clear_idle", 32'(sat_count), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      send(8'd200, 1'b0, 8'h7F, 1'b1);
      drain();
      check("sat_count_step", 32'(sat_count), (k > 3) ? 32'd3 : 32'(k));
    end
    out_ready = 1'b0;
    send(8'd130, 1'b1, 8'h80, 1'b1);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clr_race_ready", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
    check("clr_race_count", 32'(sat_count), 32'd0);
    check("clr_race_delivered", 32'(out_valid), 32'd0);

    send(8'd200, 1'b1, 8'h80, 1'b1);
    drain();
    check("pre_rst_count", 32'(sat_count), 32'd1);
    out_ready = 1'b0;
    send(8'd3, 1'b0, 8'h03, 1'b0);
    send(8'd4, 1'b1, 8'hFC, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_sat", 32'(out_sat), 32'd0);
    check("arst_sat_count", 32'(sat_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("no_stale_output", 32'(stale), 32'd0);
    latency(8'd7, 1'b1, 8'hF9, 1'b0, "t6");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
